xor_share_sched: RTL and testbench

Round-robin scheduler that shares one pipelined XOR-reduction (parity) tree between NUM_REQ requesters. It accepts words from requesters with a valid/ready handshake, drives the shared tree one word per cycle, carries a tag pipeline matched to the tree latency, and accumulates per-requester frame parity. It emits one parity result per completed frame. It sits between the lane/FEC framing logic and a single `xor_2tick`-style reduction tree instantiated beside it.

---
 rtl/xor_share_sched_if.sv | 26 ++
 rtl/xor_share_sched.sv | 90 +++++++++
 tb/tb_xor_share_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/xor_share_sched_if.sv
// Requester, shared-tree and result signals of xor_share_sched.
// The slave side is the scheduler. The master side is its environment.
interface xor_share_sched_if #(
  parameter int WIDTH   = 36,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         xor_din;
  logic                     xor_dout;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic                     res_parity;

  modport slave (
    input  req_valid, req_last, req_data, xor_dout,
    output req_ready, xor_din, res_valid, res_id, res_parity
  );
  modport master (
    output req_valid, req_last, req_data, xor_dout,
    input  req_ready, xor_din, res_valid, res_id, res_parity
  );
endinterface

// File: rtl/xor_share_sched.sv
// Round-robin scheduler that time-shares one external pipelined parity tree.
// Each requester has its own frame-parity accumulator.
module xor_share_sched #(
  parameter int WIDTH   = 36,
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 2,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               flush,
  xor_share_sched_if.slave   bus
);
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

  logic [ID_W-1:0]    last_gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic               xfer;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_last;
  tag_t [LATENCY:0]   tag_pipe;
  logic [NUM_REQ-1:0] acc;

  // Search from last_gnt+1 in cyclic order. All indices are loop constants,
  // so this unrolls into a plain priority mux.
  always_comb begin
    gnt      = '0;
    gnt_id   = last_gnt;
    found    = 1'b0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_valid[i] && ((int'(last_gnt) + k) % NUM_REQ) == i) begin
          found    = 1'b1;
          gnt[i]   = 1'b1;
          gnt_id   = ID_W'(i);
          sel_data = bus.req_data[i*WIDTH +: WIDTH];
          sel_last = bus.req_last[i];
        end
      end
    end
  end

  assign bus.req_ready = (arst || flush) ? '0 : gnt;
  assign xfer          = found && !flush;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      last_gnt       <= ID_W'(NUM_REQ - 1);
      bus.xor_din    <= '0;
      tag_pipe       <= '0;
      acc            <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_id     <= '0;
      bus.res_parity <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      if (xfer) last_gnt <= gnt_id;
      bus.xor_din <= xfer ? sel_data : '0;
      tag_pipe[0] <= '{vld: xfer, id: gnt_id, last: sel_last};
      for (int k = 1; k <= LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];

      // Flush also drops whatever sits at the accumulate stage this cycle.
      if (flush) begin
        for (int k = 0; k <= LATENCY; k++) tag_pipe[k].vld <= 1'b0;
        acc <= '0;
      end else if (tag_pipe[LATENCY].vld) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (tag_pipe[LATENCY].id == ID_W'(i)) begin
            if (tag_pipe[LATENCY].last) begin
              bus.res_parity <= acc[i] ^ bus.xor_dout;
              bus.res_id     <= ID_W'(i);
              bus.res_valid  <= 1'b1;
              acc[i]         <= 1'b0;
            end else begin
              acc[i] <= acc[i] ^ bus.xor_dout;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_xor_share_sched.sv
// Directed bench for xor_share_sched. It includes a behavioural 2-cycle parity tree.
// Expected results go into a scoreboard queue, which is drained by a separate monitor.
module tb_xor_share_sched;
  localparam int WIDTH = 36, NUM_REQ = 2, LATENCY = 2, ID_W = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            par;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t q[$];
  logic [LATENCY-1:0] tp = '0;

  xor_share_sched_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  xor_share_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .ID_W(ID_W)) dut (
    .clk(clk), .arst(arst), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External tree: the parity of xor_din, LATENCY registers later.
  always @(posedge clk) tp <= {tp[LATENCY-2:0], ^bus.xor_din};
  assign bus.xor_dout = tp[LATENCY-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // The result is registered 2+LATENCY cycles after the transfer cycle.
  task automatic expect_res(input logic [ID_W-1:0] id, input logic par);
    exp_t e;
    e.id = id; e.par = par; e.cyc = cyc + 2 + LATENCY;
    q.push_back(e);
  endtask

  // One cycle: drive inputs, check ready and the previous cycle's xor_din mid-cycle.
  task automatic step(input logic fl, input logic [1:0] v, input logic [1:0] l,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                      input logic [1:0] exp_rdy, input logic [WIDTH-1:0] exp_din);
    flush = fl;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = {d1, d0};
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("xor_din", 64'(bus.xor_din), 64'(exp_din));
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [WIDTH-1:0] exp_din);
    step(1'b0, 2'b00, 2'b00, '0, '0, 2'b00, exp_din);
  endtask

  always @(negedge clk) begin
    if (bus.res_valid) begin
      if (q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_result: got id=%0d parity=%0d at cycle %0d, want none",
                 bus.res_id, bus.res_parity, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result{id,parity,cycle}", {29'd0, bus.res_id, bus.res_parity, 32'(cyc)},
            {29'd0, e.id, e.par, 32'(e.cyc)});
      end
    end
  end

  initial begin
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b00;
    bus.req_data  = '1;

    // reset state, with ready gated despite valid inputs
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_xor_din", 64'(bus.xor_din), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);
    chk("rst_res_parity", 64'(bus.res_parity), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    bus.req_valid = 2'b00;

    // single-word frames on requester 0
    expect_res(2'd0, 1'b1);
    step(1'b0, 2'b01, 2'b01, 36'h1, '0, 2'b01, '0);
    expect_res(2'd0, 1'b0);
    step(1'b0, 2'b01, 2'b01, 36'hF_FFFF_FFFF, '0, 2'b01, 36'h1);
    idle(36'hF_FFFF_FFFF);
    repeat (4) idle('0);

    // interleaved frames: r1 single word, then r0 three words
    expect_res(2'd1, 1'b1);
    step(1'b0, 2'b11, 2'b10, 36'h1, 36'h1, 2'b10, '0);
    step(1'b0, 2'b01, 2'b00, 36'h1, '0, 2'b01, 36'h1);
    step(1'b0, 2'b01, 2'b00, 36'h3, '0, 2'b01, 36'h1);
    expect_res(2'd0, 1'b0);
    step(1'b0, 2'b01, 2'b01, 36'h7, '0, 2'b01, 36'h3);
    idle(36'h7);
    repeat (4) idle('0);

    // flush mid-frame: acc[0] holds 1 from the partial frame and must be cleared
    step(1'b0, 2'b01, 2'b00, 36'h1, '0, 2'b01, '0);
    step(1'b0, 2'b01, 2'b00, 36'h3, '0, 2'b01, 36'h1);
    idle(36'h3);
    repeat (3) idle('0);
    step(1'b1, 2'b01, 2'b01, 36'h3, '0, 2'b00, '0);
    expect_res(2'd0, 1'b0);
    step(1'b0, 2'b01, 2'b01, 36'h3, '0, 2'b01, '0);
    idle(36'h3);
    repeat (4) idle('0);

    // flush just after a last word is accepted: its result is dropped
    step(1'b0, 2'b01, 2'b01, 36'h1, '0, 2'b01, '0);
    step(1'b1, 2'b00, 2'b00, '0, '0, 2'b00, 36'h1);
    repeat (5) idle('0);

    // flush while a last word is at the accumulate stage
    step(1'b0, 2'b01, 2'b01, 36'h1, '0, 2'b01, '0);
    idle(36'h1);
    idle('0);
    step(1'b1, 2'b00, 2'b00, '0, '0, 2'b00, '0);
    repeat (5) idle('0);

    // reset mid-operation, with a result held on the outputs and a tag in flight
    expect_res(2'd1, 1'b1);
    step(1'b0, 2'b10, 2'b10, '0, 36'h1, 2'b10, '0);
    idle(36'h1);
    repeat (4) idle('0);
    step(1'b0, 2'b01, 2'b01, 36'h1, '0, 2'b01, '0);
    arst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_xor_din", 64'(bus.xor_din), 64'd0);
    chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("mid_rst_res_id", 64'(bus.res_id), 64'd0);
    chk("mid_rst_res_parity", 64'(bus.res_parity), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    bus.req_valid = 2'b00;
    repeat (5) idle('0);

    // contention: grants alternate starting at requester 0 after reset
    expect_res(2'd0, 1'b1);
    step(1'b0, 2'b11, 2'b11, 36'h1, 36'h3, 2'b01, '0);
    expect_res(2'd1, 1'b0);
    step(1'b0, 2'b11, 2'b11, 36'h1, 36'h3, 2'b10, 36'h1);
    expect_res(2'd0, 1'b1);
    step(1'b0, 2'b11, 2'b11, 36'h1, 36'h3, 2'b01, 36'h3);
    expect_res(2'd1, 1'b0);
    step(1'b0, 2'b11, 2'b11, 36'h1, 36'h3, 2'b10, 36'h1);
    idle(36'h3);
    repeat (6) idle('0);

    chk("results_outstanding", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
